spi_frame_arbiter: RTL and testbench

Shares the 16-bit SPI register link between up to `N_REQ` requesters. The block arbitrates round-robin, serializes one frame per grant and returns read data.
- Frame format: R/W bit, 7-bit register address, 8-bit data.
- Runs in the `sclk` domain and drives `cs_n`/`mosi` directly to the slave register file, in place of a fixed write-4-then-read-1 sequencer.

---
 rtl/spi_pkg.sv | 35 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/spi_frame_arbiter.sv | 141 ++++++++++++++
 tb/tb_spi_frame_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI register-link definitions: frame geometry, op codes, arbiter FSM states
// and the frame packing helper.
package spi_pkg;

  localparam int unsigned SPI_FRAME_W = 16;
  localparam int unsigned SPI_ADDR_W  = 7;
  localparam int unsigned SPI_DATA_W  = 8;

  localparam logic SPI_RD = 1'b1;
  localparam logic SPI_WR = 1'b0;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SHIFT,
    ARB_GAP
  } spi_arb_state_t;

  typedef struct packed {
    logic                  rw;
    logic [SPI_ADDR_W-1:0] addr;
    logic [SPI_DATA_W-1:0] data;
  } spi_frame_t;

  // Reads carry an all-zero data field on the wire.
  function automatic spi_frame_t spi_pack_frame(input logic                  op,
                                                input logic [SPI_ADDR_W-1:0] a,
                                                input logic [SPI_DATA_W-1:0] d);
    spi_frame_t f;
    f.rw   = op;
    f.addr = a;
    f.data = (op == SPI_RD) ? '0 : d;
    return f;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping to 0.
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  // First pass covers ptr..N-1; the wrap pass only fires when that found nothing.
  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!any && req[i] && (IDX_W'(i) >= ptr)) begin
        any     = 1'b1;
        win[i]  = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!any && req[i]) begin
        any     = 1'b1;
        win[i]  = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/spi_frame_arbiter.sv
// Round-robin sharing of one 16-bit SPI register link between N_REQ requesters:
// one frame per grant, MSB first, read data captured from miso in the data field.
module spi_frame_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned GAP_CYC = 1
) (
  input  logic                        sclk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            rw,
  input  logic [N_REQ*SPI_ADDR_W-1:0] addr,
  input  logic [N_REQ*SPI_DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            done,
  output logic [SPI_DATA_W-1:0]       rdata,
  output logic                        rdata_vld,
  output logic                        busy,
  output logic                        cs_n,
  output logic                        mosi,
  input  logic                        miso
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned BIT_W = $clog2(SPI_FRAME_W);
  localparam int unsigned RXS_W = SPI_DATA_W - 1;

  spi_arb_state_t         state;
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       win_idx;
  logic [PTR_W-1:0]       next_ptr_c;
  logic [N_REQ-1:0]       win;
  logic [N_REQ-1:0]       owner;
  logic                   any;
  logic                   launch_c;
  logic                   gap_last_c;
  logic                   is_rd;
  logic [BIT_W-1:0]       bit_cnt;
  logic [GAP_W-1:0]       gap_cnt;
  logic [SPI_FRAME_W-2:0] tx_sr;
  logic [RXS_W-1:0]       rx_sr;
  spi_frame_t             sel_frame_c;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

  // Request fields of the winning requester.
  always_comb begin
    sel_frame_c = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (win[i]) begin
        sel_frame_c = spi_pack_frame(rw[i],
                                     addr[i*SPI_ADDR_W +: SPI_ADDR_W],
                                     wdata[i*SPI_DATA_W +: SPI_DATA_W]);
      end
    end
  end

  assign next_ptr_c = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : PTR_W'(win_idx + 1'b1);
  assign gap_last_c = (state == ARB_GAP) && (gap_cnt == GAP_W'(GAP_CYC - 1));
  // Arbitration happens in IDLE and on the edge ending the last GAP cycle.
  assign launch_c   = any && ((state == ARB_IDLE) || gap_last_c);

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      owner     <= '0;
      is_rd     <= 1'b0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      rdata_vld <= 1'b0;
      busy      <= 1'b0;
      cs_n      <= 1'b1;
      mosi      <= 1'b0;
    end else begin
      gnt       <= '0;
      done      <= '0;
      rdata_vld <= 1'b0;
      if (launch_c) begin
        state   <= ARB_SHIFT;
        ptr     <= next_ptr_c;
        owner   <= win;
        gnt     <= win;
        is_rd   <= sel_frame_c.rw;
        tx_sr   <= sel_frame_c[SPI_FRAME_W-2:0];
        mosi    <= sel_frame_c.rw;
        bit_cnt <= '0;
        cs_n    <= 1'b0;
        busy    <= 1'b1;
      end else begin
        case (state)
          ARB_SHIFT: begin
            if (bit_cnt >= BIT_W'(SPI_FRAME_W - SPI_DATA_W)) begin
              rx_sr <= {rx_sr[RXS_W-2:0], miso};
            end
            if (bit_cnt == BIT_W'(SPI_FRAME_W - 1)) begin
              state   <= ARB_GAP;
              gap_cnt <= '0;
              cs_n    <= 1'b1;
              mosi    <= 1'b0;
              done    <= owner;
              if (is_rd) begin
                rdata     <= {rx_sr, miso};
                rdata_vld <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              mosi    <= tx_sr[SPI_FRAME_W-2];
              tx_sr   <= {tx_sr[SPI_FRAME_W-3:0], 1'b0};
            end
          end
          ARB_GAP: begin
            if (gap_last_c) begin
              state <= ARB_IDLE;
              busy  <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: begin
            state <= ARB_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Directed bench for spi_frame_arbiter: a vector table of single-requester frames
// plus hand sequences for contention, fairness, mid-frame reset and withdrawn requests.
module tb_spi_frame_arbiter;

  logic        sclk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  rw;
  logic [27:0] addr;
  logic [31:0] wdata;
  logic        miso;

  logic [3:0] gnt, done;
  logic [7:0] rdata;
  logic       rdata_vld, busy, cs_n, mosi;

  logic [3:0] b_gnt, b_done;
  logic [7:0] b_rdata;
  logic       b_rdata_vld, b_busy, b_cs_n, b_mosi;

  spi_frame_arbiter #(.N_REQ(4), .GAP_CYC(1)) dut (
    .sclk(sclk), .rst_n(rst_n), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .rdata_vld(rdata_vld), .busy(busy),
    .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  spi_frame_arbiter #(.N_REQ(4), .GAP_CYC(3)) dut3 (
    .sclk(sclk), .rst_n(rst_n), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .gnt(b_gnt), .done(b_done), .rdata(b_rdata), .rdata_vld(b_rdata_vld), .busy(b_busy),
    .cs_n(b_cs_n), .mosi(b_mosi), .miso(miso)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  typedef struct {
    int          idx;
    logic        rw;
    logic [6:0]  a;
    logic [7:0]  d;
    logic [7:0]  mi;
    logic [15:0] frame;
    logic [7:0]  rd;
  } vec_t;

  vec_t        tbl[6];
  int          n_vec = 0;
  int          n_bad = 0;
  int          vi;
  bit          ok;
  bit          saw3;
  logic [15:0] got;
  logic [3:0]  first_g;
  int          t_first;
  int          g_ord[4];
  int          g_t[4];
  int          g_n;
  int          g_csh;
  bit          g_busy_ok;

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_cs_n"},  32'(cs_n), 32'd1);
    check({tag, "_mosi"},  32'(mosi), 32'd0);
    check({tag, "_gnt"},   32'(gnt), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'd0);
    check({tag, "_vld"},   32'(rdata_vld), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Collect up to four grants from one instance, tracking busy and cs_n-high cycles
  // from the first grant up to the done cycle of the fourth frame.
  task automatic run_grants(input bit sel3, input bit drop);
    logic [3:0] gv;
    logic       bz, cs;
    bit         stop;
    g_n = 0; g_csh = 0; g_busy_ok = 1'b1; stop = 1'b0;
    for (int c = 0; c < 300 && !stop; c++) begin
      tick();
      gv = sel3 ? b_gnt : gnt;
      bz = sel3 ? b_busy : busy;
      cs = sel3 ? b_cs_n : cs_n;
      if (gv != 4'd0 && g_n < 4) begin
        for (int k = 0; k < 4; k++) if (gv[k]) g_ord[g_n] = k;
        g_t[g_n] = c;
        g_n++;
        if (drop) req = req & ~gv;
      end
      if (g_n > 0) begin
        if (g_n == 4 && c >= g_t[3] + 16) stop = 1'b1;
        else begin
          if (!bz) g_busy_ok = 1'b0;
          if (cs) g_csh++;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = '0; rw = '0; addr = '0; wdata = '0; miso = 1'b0;
    //            idx rw    addr   wdata  miso   frame     rdata after
    tbl[0] = '{0, 1'b0, 7'h01, 8'hA5, 8'h00, 16'h01A5, 8'h00};
    tbl[1] = '{1, 1'b1, 7'h03, 8'h77, 8'h3C, 16'h8300, 8'h3C};
    tbl[2] = '{2, 1'b0, 7'h7F, 8'h00, 8'hFF, 16'h7F00, 8'h3C};
    tbl[3] = '{3, 1'b1, 7'h55, 8'hFF, 8'hC3, 16'hD500, 8'hC3};
    tbl[4] = '{2, 1'b1, 7'h00, 8'h12, 8'h81, 16'h8000, 8'h81};
    tbl[5] = '{0, 1'b0, 7'h2A, 8'h5A, 8'h66, 16'h2A5A, 8'h81};

    repeat (3) tick();
    check_rst("init");
    rst_n = 1'b1;
    repeat (2) tick();

    // Single-requester frames from the table
    for (int v = 0; v < 6; v++) begin
      vi = tbl[v].idx;
      req = '0;
      req[vi] = 1'b1;
      rw[vi] = tbl[v].rw;
      addr[vi*7 +: 7] = tbl[v].a;
      wdata[vi*8 +: 8] = tbl[v].d;
      tick();
      check($sformatf("v%0d_gnt", v), 32'(gnt), 32'd1 << vi);
      check($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
      req[vi] = 1'b0;
      addr[vi*7 +: 7] = ~tbl[v].a;
      wdata[vi*8 +: 8] = ~tbl[v].d;
      ok = 1'b1;
      got = '0;
      for (int b = 0; b < 16; b++) begin
        got[15-b] = mosi;
        if (cs_n !== 1'b0 || done !== 4'd0 || busy !== 1'b1 || rdata_vld !== 1'b0) ok = 1'b0;
        if (b > 0 && gnt !== 4'd0) ok = 1'b0;
        miso = (b >= 8) ? tbl[v].mi[15-b] : 1'($urandom);
        tick();
      end
      check($sformatf("v%0d_shift_phase", v), 32'(ok), 32'd1);
      check($sformatf("v%0d_mosi_frame", v), 32'(got), 32'(tbl[v].frame));
      check($sformatf("v%0d_gap_cs_n", v), 32'(cs_n), 32'd1);
      check($sformatf("v%0d_done", v), 32'(done), 32'd1 << vi);
      check($sformatf("v%0d_rdata_vld", v), 32'(rdata_vld), 32'(tbl[v].rw));
      check($sformatf("v%0d_rdata", v), 32'(rdata), 32'(tbl[v].rd));
      tick();
      check($sformatf("v%0d_idle_busy", v), 32'(busy), 32'd0);
      check($sformatf("v%0d_idle_vld", v), 32'(rdata_vld), 32'd0);
      check($sformatf("v%0d_rdata_hold", v), 32'(rdata), 32'(tbl[v].rd));
      repeat (3) tick();
    end

    // Reset at bit_cnt 7 of a req0 frame; ptr had advanced to 1 before reset
    req = '0; rw = '0;
    req[0] = 1'b1; addr[6:0] = 7'h11; wdata[7:0] = 8'h22;
    tick();
    check("mf_gnt0", 32'(gnt), 32'd1);
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    check_rst("mf");
    req[1] = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("mf_first_gnt", 32'(gnt), 32'd1);
    req[0] = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done !== 4'd0) ok = 1'b0;
    end
    check("mf_no_stale_done", 32'(ok), 32'd1);
    tick();
    check("mf_done0", 32'(done), 32'd1);
    tick();
    check("mf_gnt1", 32'(gnt), 32'd2);
    req = '0;
    repeat (20) tick();

    // All four requesters at once, each dropping on its grant
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      addr[k*7 +: 7] = 7'(8 + k);
      wdata[k*8 +: 8] = 8'(8'h40 + k);
    end
    req = 4'hF;
    run_grants(1'b0, 1'b1);
    check("a4_grants", 32'(g_n), 32'd4);
    if (g_n == 4) begin
      for (int k = 0; k < 4; k++) check($sformatf("a4_order%0d", k), 32'(g_ord[k]), 32'(k));
      for (int k = 0; k < 3; k++) check($sformatf("a4_period%0d", k), 32'(g_t[k+1] - g_t[k]), 32'd17);
    end
    check("a4_busy_high", 32'(g_busy_ok), 32'd1);
    check("a4_cs_high_cycles", 32'(g_csh), 32'd3);
    req = '0;
    repeat (30) tick();

    // Fairness on the GAP_CYC=3 instance: req0 and req2 held throughout
    pulse_reset();
    req = 4'b0101;
    run_grants(1'b1, 1'b0);
    check("fair_grants", 32'(g_n), 32'd4);
    if (g_n == 4) begin
      for (int k = 0; k < 4; k++) check($sformatf("fair_order%0d", k), 32'(g_ord[k]), 32'((k % 2) * 2));
      for (int k = 0; k < 3; k++) check($sformatf("fair_period%0d", k), 32'(g_t[k+1] - g_t[k]), 32'd19);
    end
    check("fair_busy_high", 32'(g_busy_ok), 32'd1);
    check("fair_cs_high_cycles", 32'(g_csh), 32'd9);
    req = '0;
    repeat (30) tick();

    // req3 pulses one cycle during a req1 frame; req0 then waits
    pulse_reset();
    rw = '0;
    req[1] = 1'b1;
    tick();
    check("wd_gnt1", 32'(gnt), 32'd2);
    req[1] = 1'b0;
    repeat (4) tick();
    req[3] = 1'b1;
    tick();
    req[3] = 1'b0;
    req[0] = 1'b1;
    saw3 = 1'b0; first_g = '0; t_first = -1;
    for (int c = 6; c < 60; c++) begin
      tick();
      if (gnt[3] === 1'b1) saw3 = 1'b1;
      if (gnt != 4'd0 && first_g == 4'd0) begin
        first_g = gnt;
        t_first = c;
        req[0] = 1'b0;
      end
    end
    check("wd_next_gnt", 32'(first_g), 32'd1);
    check("wd_next_delay", 32'(t_first), 32'd17);
    check("wd_no_gnt3", 32'(saw3), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
